sd_clock_monitor: RTL and testbench

Receive-side checker for the SD card clock. It samples the divided SD clock produced by the SD clock divider in the host `CLK` domain. From the level run lengths it recovers the effective `DIVIDER` value and reports lock, loss-of-lock and stopped-clock status. It sits beside the divider in the SD host core and lets firmware and benches confirm that a programmed divider value took effect.

---
 rtl/sd_clk_mon_pkg.sv | 23 ++
 rtl/sd_clk_run_meter.sv | 49 ++++
 rtl/sd_clock_monitor.sv | 146 ++++++++++++++
 tb/tb_sd_clock_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_clk_mon_pkg.sv
// rtl/sd_clk_mon_pkg.sv - shared state type, run width and helpers for the SD clock monitor
package sd_clk_mon_pkg;

  localparam int SD_CLK_MON_RUN_W = 10;

  typedef enum logic [1:0] {
    NOCLK = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2
  } sd_clk_mon_state_t;

  // Half-period length L corresponds to a divider value of L-1.
  function automatic logic [7:0] run_to_div(input logic [SD_CLK_MON_RUN_W-1:0] run);
    logic [SD_CLK_MON_RUN_W-1:0] div;
    div = run - SD_CLK_MON_RUN_W'(1);
    return div[7:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/sd_clk_run_meter.sv
// rtl/sd_clk_run_meter.sv - SD clock sample pipeline, edge detect and saturating run counter
module sd_clk_run_meter
  import sd_clk_mon_pkg::*;
#(
  parameter int TIMEOUT = 300
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sd_clk_i,
  output logic                        sd_edge,
  output logic [SD_CLK_MON_RUN_W-1:0] run_len,
  output logic                        timeout
);

  localparam logic [SD_CLK_MON_RUN_W-1:0] TIMEOUT_V = SD_CLK_MON_RUN_W'(TIMEOUT);

  logic                        d1_q, d1_d;
  logic                        d2_q, d2_d;
  logic [SD_CLK_MON_RUN_W-1:0] run_q, run_d;

  always_comb begin
    d1_d    = sd_clk_i;
    d2_d    = d1_q;
    sd_edge = (d1_q != d2_q);
    run_len = run_q;
    // An edge always wins, so a stopped clock restarting is never swallowed.
    timeout = (run_q == TIMEOUT_V) && !sd_edge;
    if (sd_edge) begin
      run_d = SD_CLK_MON_RUN_W'(1);
    end else if (run_q != TIMEOUT_V) begin
      run_d = run_q + SD_CLK_MON_RUN_W'(1);
    end else begin
      run_d = run_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q  <= 1'b0;
      d2_q  <= 1'b0;
      run_q <= '0;
    end else begin
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/sd_clock_monitor.sv
// rtl/sd_clock_monitor.sv - recovers the SD clock divider and reports lock/stop; SD_CLK_MON_CNT_EN enables CHANGE_CNT
module sd_clock_monitor
  import sd_clk_mon_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 300
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SD_CLK_I,
  input  logic [7:0] EXPECTED,
  output logic [7:0] MEASURED,
  output logic       LOCKED,
  output logic       MISMATCH,
  output logic       STOPPED,
  output logic       LOST,
  output logic [7:0] CHANGE_CNT
);

  localparam int MATCH_W = 4;

  logic                        sd_edge;
  logic                        timeout;
  logic [SD_CLK_MON_RUN_W-1:0] run_len;

  sd_clk_mon_state_t           state_q, state_d;
  logic [SD_CLK_MON_RUN_W-1:0] cand_q, cand_d;
  logic [MATCH_W-1:0]          match_q, match_d;
  logic [7:0]                  measured_q, measured_d;
  logic                        locked_q, locked_d;
  logic                        mismatch_q, mismatch_d;
  logic                        stopped_q, stopped_d;
  logic                        lost_q, lost_d;

  sd_clk_run_meter #(
    .TIMEOUT (TIMEOUT)
  ) u_run_meter (
    .clk      (CLK),
    .rst      (RST),
    .sd_clk_i (SD_CLK_I),
    .sd_edge  (sd_edge),
    .run_len  (run_len),
    .timeout  (timeout)
  );

  // cand==0 means "no candidate": completed runs are always at least 1 long.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    match_d    = match_q;
    measured_d = measured_q;
    if (sd_edge) begin
      case (state_q)
        NOCLK: begin
          state_d = ACQ;
          cand_d  = '0;
          match_d = '0;
        end
        ACQ: begin
          if (run_len == cand_q) begin
            match_d = match_q + MATCH_W'(1);
          end else begin
            cand_d  = run_len;
            match_d = MATCH_W'(1);
          end
          if (match_d == MATCH_W'(LOCK_COUNT)) begin
            state_d    = LOCK;
            measured_d = run_to_div(cand_d);
          end
        end
        LOCK: begin
          if (run_len != cand_q) begin
            state_d = ACQ;
            cand_d  = run_len;
            match_d = MATCH_W'(1);
          end
        end
        default: begin
          state_d = NOCLK;
          cand_d  = '0;
          match_d = '0;
        end
      endcase
    end else if (timeout) begin
      state_d = NOCLK;
      cand_d  = '0;
      match_d = '0;
    end
    locked_d   = (state_d == LOCK);
    stopped_d  = (state_d == NOCLK);
    lost_d     = (state_q == LOCK) && (state_d != LOCK);
    mismatch_d = locked_d && (measured_d != EXPECTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= NOCLK;
      cand_q     <= '0;
      match_q    <= '0;
      measured_q <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      stopped_q  <= 1'b1;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      match_q    <= match_d;
      measured_q <= measured_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      stopped_q  <= stopped_d;
      lost_q     <= lost_d;
    end
  end

`ifdef SD_CLK_MON_CNT_EN
  logic [7:0] change_cnt_q, change_cnt_d;

  always_comb begin
    change_cnt_d = change_cnt_q;
    if (lost_d) begin
      change_cnt_d = sat_inc8(change_cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      change_cnt_q <= '0;
    end else begin
      change_cnt_q <= change_cnt_d;
    end
  end

  assign CHANGE_CNT = change_cnt_q;
`else
  assign CHANGE_CNT = 8'd0;
`endif

  assign MEASURED = measured_q;
  assign LOCKED   = locked_q;
  assign MISMATCH = mismatch_q;
  assign STOPPED  = stopped_q;
  assign LOST     = lost_q;

endmodule

// File: tb/tb_sd_clock_monitor.sv
// tb/tb_sd_clock_monitor.sv - self-checking bench for sd_clock_monitor
module tb_sd_clock_monitor;

  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 300;
`ifdef SD_CLK_MON_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  // generator modes: normal divider, hold level, bypass (sampled as constant), random noise
  localparam int M_DIV = 0;
  localparam int M_HOLD = 1;
  localparam int M_BYP = 2;
  localparam int M_NOISE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sd_clk = 1'b0;
  logic [7:0] expected = 8'd0;
  logic [7:0] measured;
  logic       locked, mismatch, stopped, lost;
  logic [7:0] change_cnt;

  always #5 clk = ~clk;

  sd_clock_monitor #(
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .SD_CLK_I   (sd_clk),
    .EXPECTED   (expected),
    .MEASURED   (measured),
    .LOCKED     (locked),
    .MISMATCH   (mismatch),
    .STOPPED    (stopped),
    .LOST       (lost),
    .CHANGE_CNT (change_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock means the latest run lengths since the clock appeared
  // end in a stretch of at least LOCK_COUNT equal values.
  int  m_d1 = 0, m_d2 = 0, m_cnt = 0;
  bit  m_active = 0, m_was_locked = 0;
  int  m_runs[$];
  int  e_meas = 0, e_locked = 0, e_mm = 0, e_stop = 1, e_lost = 0, e_chg = 0;

  function automatic int trailing_equal();
    int n = 0;
    for (int i = m_runs.size() - 1; i >= 0; i--) begin
      if (m_runs[i] != m_runs[m_runs.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step(input bit r, input int s, input int exp);
    bit sd_edge_seen;
    int l;
    if (r) begin
      m_d1 = 0; m_d2 = 0; m_cnt = 0; m_active = 0; m_was_locked = 0;
      m_runs.delete();
      e_meas = 0; e_locked = 0; e_mm = 0; e_stop = 1; e_lost = 0; e_chg = 0;
      return;
    end
    sd_edge_seen = (m_d1 != m_d2);
    l = m_cnt;
    if (sd_edge_seen) begin
      if (!m_active) begin
        m_active = 1;
        m_runs.delete();
      end else begin
        m_runs.push_back(l);
        if (m_runs.size() > 16) void'(m_runs.pop_front());
      end
    end else if (m_cnt == TIMEOUT) begin
      m_active = 0;
      m_runs.delete();
    end
    e_locked = (m_active && trailing_equal() >= LOCK_COUNT) ? 1 : 0;
    if (e_locked != 0) e_meas = (m_runs[m_runs.size() - 1] - 1) % 256;
    e_lost = (m_was_locked && e_locked == 0) ? 1 : 0;
    if (e_lost != 0 && CNT_EN != 0 && e_chg < 255) e_chg++;
    e_stop = m_active ? 0 : 1;
    e_mm = (e_locked != 0 && e_meas != exp) ? 1 : 0;
    m_was_locked = (e_locked != 0);
    m_cnt = sd_edge_seen ? 1 : ((m_cnt < TIMEOUT) ? m_cnt + 1 : m_cnt);
    m_d2 = m_d1;
    m_d1 = s;
  endtask

  // SD clock source: level toggles every div+1 host cycles
  int cur_div = -1, gen_cnt = 0, sd_level = 0, lost_seen = 0;

  task automatic tick(input bit r, input int mode, input int div, input int exp);
    logic [31:0] want;
    if (r) begin
      sd_level = 0; cur_div = -1; gen_cnt = 0;
    end else if (mode == M_BYP) begin
      sd_level = 0; cur_div = -1;
    end else if (mode == M_HOLD) begin
      cur_div = -1;
    end else if (mode == M_NOISE) begin
      sd_level = $urandom_range(0, 1); cur_div = -1;
    end else begin
      if (div != cur_div) begin
        cur_div = div; gen_cnt = 0;
      end
      gen_cnt++;
      if (gen_cnt == div + 1) begin
        sd_level = 1 - sd_level; gen_cnt = 0;
      end
    end
    rst = r;
    sd_clk = sd_level[0];
    expected = exp[7:0];
    @(posedge clk);
    model_step(r, sd_level, exp % 256);
    @(negedge clk);
    if (lost) lost_seen++;
    want = {12'd0, e_meas[7:0], e_locked[0], e_mm[0], e_stop[0], e_lost[0], e_chg[7:0]};
    check("cycle", {12'd0, measured, locked, mismatch, stopped, lost, change_cnt}, want);
  endtask

  typedef struct {
    int mode; int div; int exp; int cycles;
    bit locked; int meas; bit stopped; bit mm; int lost_n; int chg;
  } vec_t;

  vec_t vt[9];

  initial begin
    int first, lockat, bad, div, ex, cyc;
    vt[0] = '{M_DIV,   3,   3,   40, 1,   3, 0, 0, -1, 0};
    vt[1] = '{M_DIV,  10,   3,  120, 1,  10, 0, 1,  1, 1};
    vt[2] = '{M_DIV,  10,  10,    2, 1,  10, 0, 0, -1, 1};
    vt[3] = '{M_DIV, 255, 255, 1900, 1, 255, 0, 0,  1, 2};
    vt[4] = '{M_HOLD,  0, 255,  310, 0, 255, 1, 0,  1, 3};
    vt[5] = '{M_BYP,   0, 255,  400, 0, 255, 1, 0,  0, 3};
    vt[6] = '{M_DIV,   5,   5,   80, 1,   5, 0, 0,  0, 3};
    vt[7] = '{M_DIV,   5,   6,    1, 1,   5, 0, 1, -1, 3};
    vt[8] = '{M_DIV,   5,   5,    1, 1,   5, 0, 0, -1, 3};

    repeat (3) tick(1, M_DIV, 3, 3);
    check("reset_outs", {12'd0, measured, locked, mismatch, stopped, lost, change_cnt},
          {12'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});

    first = -1; lockat = -1;
    for (int i = 0; i < 60; i++) begin
      int prev;
      prev = sd_level;
      tick(0, M_DIV, 3, 3);
      if (sd_level != prev && first < 0) first = i;
      if (locked && lockat < 0) lockat = i;
    end
    check("lock_time_ok", (lockat >= 0 && lockat - first >= 15 && lockat - first <= 25), 1);

    for (int v = 0; v < 9; v++) begin
      lost_seen = 0;
      for (int c = 0; c < vt[v].cycles; c++) tick(0, vt[v].mode, vt[v].div, vt[v].exp);
      check("row_locked", locked, vt[v].locked);
      check("row_measured", measured, vt[v].meas);
      check("row_stopped", stopped, vt[v].stopped);
      check("row_mismatch", mismatch, vt[v].mm);
      check("row_change_cnt", change_cnt, vt[v].chg * CNT_EN);
      if (vt[v].lost_n >= 0) check("row_lost_pulses", lost_seen, vt[v].lost_n);
    end

    lost_seen = 0;
    tick(1, M_DIV, 5, 5);
    check("rst_locked_outs", {12'd0, measured, locked, mismatch, stopped, lost, change_cnt},
          {12'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
    for (int c = 0; c < 80; c++) tick(0, M_DIV, 5, 5);
    check("rst_no_lost", lost_seen, 0);
    check("relock_locked", locked, 1);
    check("relock_measured", measured, 5);

    tick(1, M_BYP, 0, 0);
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      tick(0, M_BYP, 0, 0);
      if (!stopped || locked) bad++;
    end
    check("bypass_stopped", bad, 0);

    for (int it = 0; it < 8; it++) begin
      div = $urandom_range(1, 40);
      ex = ($urandom_range(0, 1) == 1) ? div : $urandom_range(0, 255);
      cyc = (div + 1) * 14 + 10;
      for (int c = 0; c < cyc; c++) tick(0, M_DIV, div, ex);
      for (int c = 0; c < 30; c++) tick(0, M_NOISE, 0, ex);
      if ($urandom_range(0, 2) == 0) begin
        for (int c = 0; c < 305; c++) tick(0, M_HOLD, 0, ex);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
